// File: rtl/code_event_counter.sv
// -----------------------------------------------------------------------------
// code_event_counter
//
// Watches the 2-bit output code of the sequence state machine and counts
// rising occurrences of each non-zero code (01, 10, 11) plus a running total.
// All four counters saturate at their maximum value, and each has a sticky
// saturation flag. A small IDLE/RUN/HOLD controller gates counting. A
// one-cycle-latency read port returns any counter.
//
// Parameters:
//   CNT_W     width of each counter and of rd_data (minimum 2)
//
// Ports:
//   clock     in   system clock, rising edge
//   reset     in   asynchronous active-high reset
//   in_code   in   [1:0] code sampled every clock
//   start     in   pulse: IDLE/HOLD -> RUN
//   stop      in   pulse: RUN -> HOLD
//   clear     in   synchronous clear of counters and saturation flags
//   rd_req    in   one-cycle read request
//   rd_sel    in   [1:0] 00 = total, 01/10/11 = counter for that code
//   rd_valid  out  high for one cycle, the cycle after rd_req
//   rd_data   out  [CNT_W-1:0] captured counter value, held between reads
//   running   out  high while the controller is in RUN
//   any_sat   out  OR of the four sticky saturation flags
// -----------------------------------------------------------------------------
module code_event_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [1:0]       in_code,
   input  logic             start,
   input  logic             stop,
   input  logic             clear,
   input  logic             rd_req,
   input  logic [1:0]       rd_sel,
   output logic             rd_valid,
   output logic [CNT_W-1:0] rd_data,
   output logic             running,
   output logic             any_sat
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_HOLD = 2'b10
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   // Index 0 of the counter array holds the total; indices 1..3 match the code.
   state_t           state_r;
   state_t           state_next_s;
   logic [1:0]       prev_code_r;
   logic [CNT_W-1:0] cnt_r      [4];
   logic [CNT_W-1:0] cnt_next_s [4];
   logic [3:0]       sat_r;
   logic [3:0]       sat_next_s;
   logic             event_s;
   logic             running_r;
   logic             any_sat_r;
   logic             rd_valid_r;
   logic [CNT_W-1:0] rd_data_r;

   // True when a counter can no longer increment.
   function automatic logic at_max(input logic [CNT_W-1:0] value);
      return (value == CNT_MAX);
   endfunction

   // Controller next state: each state reacts only to its own exit pulse.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_next_s = ST_RUN;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (stop) begin
               state_next_s = ST_HOLD;
            end else begin
               state_next_s = ST_RUN;
            end
         end
         ST_HOLD: begin
            if (start) begin
               state_next_s = ST_RUN;
            end else begin
               state_next_s = ST_HOLD;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // Event detect: a new non-zero code that differs from last cycle's code.
   // A code already present when RUN is entered matches prev_code_r, so it
   // is not counted.
   always_comb begin
      event_s = 1'b0;
      if ((state_r == ST_RUN) && (in_code != 2'b00) && (in_code != prev_code_r)) begin
         event_s = 1'b1;
      end else begin
         event_s = 1'b0;
      end
   end

   // Counter and flag next values; clear wins over a same-cycle event.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         cnt_next_s[i] = cnt_r[i];
      end
      sat_next_s = sat_r;
      if (clear) begin
         for (int i = 0; i < 4; i++) begin
            cnt_next_s[i] = CNT_ZERO;
         end
         sat_next_s = 4'b0000;
      end else if (event_s) begin
         for (int i = 0; i < 4; i++) begin
            if ((i == 0) || (2'(i) == in_code)) begin
               if (at_max(cnt_r[i])) begin
                  sat_next_s[i] = 1'b1;
               end else begin
                  cnt_next_s[i] = cnt_r[i] + CNT_ONE;
               end
            end else begin
               cnt_next_s[i] = cnt_r[i];
            end
         end
      end else begin
         sat_next_s = sat_r;
      end
   end

   // Controller state, code history and the registered running flag.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         prev_code_r <= 2'b00;
         running_r   <= 1'b0;
      end else begin
         state_r     <= state_next_s;
         prev_code_r <= in_code;
         running_r   <= (state_next_s == ST_RUN);
      end
   end

   // Counters, sticky saturation flags and their registered OR.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            cnt_r[i] <= CNT_ZERO;
         end
         sat_r     <= 4'b0000;
         any_sat_r <= 1'b0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            cnt_r[i] <= cnt_next_s[i];
         end
         sat_r     <= sat_next_s;
         any_sat_r <= |sat_next_s;
      end
   end

   // Read port: captures the pre-update counter value, so a read issued with
   // clear or with an event returns the value from before that edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_valid_r <= 1'b0;
         rd_data_r  <= CNT_ZERO;
      end else begin
         rd_valid_r <= rd_req;
         if (rd_req) begin
            rd_data_r <= cnt_r[rd_sel];
         end else begin
            rd_data_r <= rd_data_r;
         end
      end
   end

   assign rd_valid = rd_valid_r;
   assign rd_data  = rd_data_r;
   assign running  = running_r;
   assign any_sat  = any_sat_r;

endmodule

// File: doc/code_event_counter.md
Name: code_event_counter

Overview:
- Downstream monitor for the 2-bit state-machine output bus (`out_data` of the sequence state machine).
- Counts rising occurrences of each non-zero code (01, 10, 11) plus a total, in saturating counters.
- Provides a one-cycle-latency read port and start/stop/clear control, so benches and the lab top level can observe detector activity without waveform inspection.

Parameters:
- CNT_W, 8, width of each event counter and of rd_data (min 2).

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_code  in  2  code from the state machine output, sampled every clock.
- start  in  1  pulse; IDLE/HOLD -> RUN.
- stop  in  1  pulse; RUN -> HOLD.
- clear  in  1  synchronous clear of counters and saturation flags.
- rd_req  in  1  read request, one cycle.
- rd_sel  in  2  00 = total, 01/10/11 = counter for that code.
- rd_valid  out  1  high for exactly one cycle, the cycle after rd_req.
- rd_data  out  CNT_W  selected counter value, valid while rd_valid = 1.
- running  out  1  1 when FSM is in RUN.
- any_sat  out  1  OR of the four sticky saturation flags.

Behaviour:
- Reset (async, while reset = 1):
  - FSM = IDLE.
  - prev_code = 00.
  - All counters = 0; all saturation flags = 0.
  - rd_valid = 0, rd_data = 0, running = 0, any_sat = 0.
- FSM states IDLE, RUN, HOLD; encoding is free.
  - IDLE: start -> RUN; stop ignored.
  - RUN: stop -> HOLD; start ignored.
  - HOLD: start -> RUN; stop ignored.
  - start and stop asserted together: each state reacts only to its own exit condition.
  - clear never changes the FSM state.
- prev_code <= in_code every cycle, in all states.
- Event k (k = 1, 2, 3) occurs in a cycle when in_code == k and prev_code != k.
  - A code held across cycles counts once.
  - Events are counted only when the FSM is in RUN during that cycle (state before the edge).
  - A code already present when RUN is entered is not counted, because prev_code already equals it.
- On an event k:
  - cnt[k] increments by 1 and total increments by 1.
  - At most one event per cycle.
- Saturation:
  - A counter at 2^CNT_W - 1 holds its value.
  - An event arriving while that counter is at maximum sets its sticky sat flag.
  - total saturates and flags independently of the per-code counters.
- clear:
  - Next edge: all counters = 0 and all sat flags = 0.
  - Priority over an event in the same cycle; that event is lost.
  - prev_code still updates.
- Read:
  - rd_req at edge N captures the counter selected by rd_sel, using its value before any increment at edge N.
  - rd_valid = 1 and rd_data = captured value during cycle N+1.
  - Back-to-back rd_req gives rd_valid on consecutive cycles.
  - rd_data holds its last value when rd_valid = 0.
  - rd_req together with clear returns the pre-clear value.
- Reset mid-operation: immediate return to the reset values above; a pending read is dropped (rd_valid = 0).
- Latency: in_code to counter update is 1 clock; rd_req to rd_data is 1 clock.

Test Plan:
1. Reset, start, then in_code 00,01,00,01 (one clock each) -> cnt1 = 2, total = 2, cnt2 = cnt3 = 0; read sel 01 gives rd_valid one cycle later with rd_data = 2.
2. In RUN, in_code 10,00,01 repeated twice, then 11 held for 3 clocks -> cnt2 = 2, cnt1 = 2, cnt3 = 1, total = 5.
3. Set CNT_W = 4; 17 events of code 10 (alternating with 00) -> cnt2 = 15, total = 15, any_sat = 1. Then clear -> all counters 0, any_sat = 0.
4. Stop after 2 events of code 01 (HOLD), apply 3 more 00/01 pairs -> cnt1 stays 2, running = 0. Start again, one more 00/01 pair -> cnt1 = 3.
5. clear, rd_req (sel 00) and an 01 event in the same cycle -> rd_data = old total; next read returns 0.
6. Assert reset mid-sequence with cnt1 = 3 -> outputs zero immediately; after release the FSM is in IDLE and events are ignored until start.
